// File: rtl/vending_if.sv
// Handshake bundle between the coin/keypad front end, the vending sequencer
// and the dispenser / coin-return actuators.
interface vending_if;
    logic        coin_valid;
    logic [1:0]  coin_val;
    logic        sel_valid;
    logic [2:0]  sel;
    logic        cancel;
    logic [11:0] credit;
    logic        dispense;
    logic [2:0]  drink;
    logic [11:0] change;
    logic        change_valid;
    logic        fault;
    logic        coin_reject;
    logic        busy;

    modport master (
        output coin_valid, coin_val, sel_valid, sel, cancel,
        input  credit, dispense, drink, change, change_valid, fault, coin_reject, busy
    );

    modport slave (
        input  coin_valid, coin_val, sel_valid, sel, cancel,
        output credit, dispense, drink, change, change_valid, fault, coin_reject, busy
    );
endinterface

// File: rtl/vending_sequencer.sv
// Control FSM for the vending machine: coin credit, price check, dispense
// strobe and change/refund payout. Every output comes straight from a flop.
module vending_sequencer #(
    parameter int TIMEOUT_CYC  = 1000,
    parameter int DISPENSE_CYC = 4,
    parameter int MAX_CREDIT   = 1000
) (
    input  logic      clk,
    input  logic      rst,
    vending_if.slave  bus
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_CREDIT   = 3'd1;
    localparam logic [2:0] S_CHECK    = 3'd2;
    localparam logic [2:0] S_DISPENSE = 3'd3;
    localparam logic [2:0] S_CHANGE   = 3'd4;

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int DW = $clog2(DISPENSE_CYC + 1);

    function automatic logic [11:0] coin_value(input logic [1:0] code);
        case (code)
            2'b00:   coin_value = 12'd25;
            2'b01:   coin_value = 12'd50;
            2'b10:   coin_value = 12'd100;
            2'b11:   coin_value = 12'd500;
            default: coin_value = 12'd0;
        endcase
    endfunction

    // A price of zero marks an invalid drink code.
    function automatic logic [11:0] drink_price(input logic [2:0] code);
        case (code)
            3'b001:  drink_price = 12'd300;
            3'b010:  drink_price = 12'd400;
            3'b011:  drink_price = 12'd500;
            3'b100:  drink_price = 12'd700;
            default: drink_price = 12'd0;
        endcase
    endfunction

    logic [2:0]    state_r, state_s;
    logic [11:0]   credit_r, credit_s;
    logic [11:0]   change_amt_r, change_amt_s;
    logic [11:0]   change_r, change_s;
    logic [2:0]    sel_r, sel_s;
    logic [TW-1:0] tmr_r, tmr_s;
    logic [DW-1:0] dcnt_r, dcnt_s;
    logic          change_valid_r, change_valid_s;
    logic          fault_r, fault_s;
    logic          coin_reject_r, coin_reject_s;
    logic          dispense_r, dispense_s;
    logic [2:0]    drink_r, drink_s;
    logic          busy_r, busy_s;
    logic [12:0]   coin_sum_s;
    logic          coin_ok_s;
    logic          activity_s;

    // Next-state and next-output computation for every register.
    always_comb begin
        state_s        = state_r;
        credit_s       = credit_r;
        change_amt_s   = change_amt_r;
        change_s       = change_r;
        sel_s          = sel_r;
        tmr_s          = tmr_r;
        dcnt_s         = dcnt_r;
        change_valid_s = 1'b0;
        fault_s        = 1'b0;
        coin_reject_s  = 1'b0;
        // 13-bit sum so a coin on top of near-maximum credit cannot wrap.
        coin_sum_s     = {1'b0, credit_r} + {1'b0, coin_value(bus.coin_val)};
        coin_ok_s      = bus.coin_valid && (coin_sum_s <= 13'(MAX_CREDIT));
        activity_s     = bus.coin_valid || bus.sel_valid || bus.cancel;

        case (state_r)
            S_IDLE: begin
                credit_s = 12'd0;
                tmr_s    = '0;
                if (coin_ok_s) begin
                    credit_s = coin_sum_s[11:0];
                    state_s  = S_CREDIT;
                end else begin
                    coin_reject_s = bus.coin_valid;
                end
                fault_s = bus.sel_valid;
            end
            S_CREDIT: begin
                if (coin_ok_s) begin
                    credit_s = coin_sum_s[11:0];
                end else begin
                    coin_reject_s = bus.coin_valid;
                end
                if (activity_s) begin
                    tmr_s = '0;
                end else begin
                    tmr_s = tmr_r + TW'(1);
                end
                if (bus.cancel) begin
                    change_s       = credit_s;
                    change_valid_s = 1'b1;
                    state_s        = S_CHANGE;
                end else if (bus.sel_valid) begin
                    if (drink_price(bus.sel) != 12'd0) begin
                        sel_s   = bus.sel;
                        state_s = S_CHECK;
                    end else begin
                        fault_s = 1'b1;
                    end
                end else if (!activity_s && (tmr_r == TW'(TIMEOUT_CYC - 1))) begin
                    change_s       = credit_r;
                    change_valid_s = 1'b1;
                    state_s        = S_CHANGE;
                end else begin
                    state_s = S_CREDIT;
                end
            end
            S_CHECK: begin
                coin_reject_s = bus.coin_valid;
                if (credit_r >= drink_price(sel_r)) begin
                    change_amt_s = credit_r - drink_price(sel_r);
                    dcnt_s       = '0;
                    state_s      = S_DISPENSE;
                end else begin
                    fault_s = 1'b1;
                    tmr_s   = '0;
                    state_s = S_CREDIT;
                end
            end
            S_DISPENSE: begin
                coin_reject_s = bus.coin_valid;
                if (dcnt_r == DW'(DISPENSE_CYC - 1)) begin
                    change_s       = change_amt_r;
                    change_valid_s = 1'b1;
                    state_s        = S_CHANGE;
                end else begin
                    dcnt_s = dcnt_r + DW'(1);
                end
            end
            S_CHANGE: begin
                coin_reject_s = bus.coin_valid;
                credit_s      = 12'd0;
                sel_s         = 3'd0;
                tmr_s         = '0;
                state_s       = S_IDLE;
            end
            default: begin
                credit_s = 12'd0;
                state_s  = S_IDLE;
            end
        endcase

        dispense_s = (state_s == S_DISPENSE);
        drink_s    = dispense_s ? sel_s : 3'd0;
        busy_s     = (state_s == S_CHECK) || (state_s == S_DISPENSE) || (state_s == S_CHANGE);
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= S_IDLE;
            credit_r       <= 12'd0;
            change_amt_r   <= 12'd0;
            change_r       <= 12'd0;
            sel_r          <= 3'd0;
            tmr_r          <= '0;
            dcnt_r         <= '0;
            change_valid_r <= 1'b0;
            fault_r        <= 1'b0;
            coin_reject_r  <= 1'b0;
            dispense_r     <= 1'b0;
            drink_r        <= 3'd0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_s;
            credit_r       <= credit_s;
            change_amt_r   <= change_amt_s;
            change_r       <= change_s;
            sel_r          <= sel_s;
            tmr_r          <= tmr_s;
            dcnt_r         <= dcnt_s;
            change_valid_r <= change_valid_s;
            fault_r        <= fault_s;
            coin_reject_r  <= coin_reject_s;
            dispense_r     <= dispense_s;
            drink_r        <= drink_s;
            busy_r         <= busy_s;
        end
    end

    assign bus.credit       = credit_r;
    assign bus.change       = change_r;
    assign bus.change_valid = change_valid_r;
    assign bus.fault        = fault_r;
    assign bus.coin_reject  = coin_reject_r;
    assign bus.dispense     = dispense_r;
    assign bus.drink        = drink_r;
    assign bus.busy         = busy_r;
endmodule

// File: tb/tb_vending_sequencer.sv
// Directed self-checking bench for vending_sequencer (default parameters).
module tb_vending_sequencer;
    logic clk;
    logic rst;
    int   tests_run;
    int   fails;

    vending_if bus();

    vending_sequencer #(.TIMEOUT_CYC(1000), .DISPENSE_CYC(4), .MAX_CREDIT(1000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic coin(input logic [1:0] code);
        bus.coin_valid = 1'b1;
        bus.coin_val   = code;
        tick();
        bus.coin_valid = 1'b0;
    endtask

    task automatic select(input logic [2:0] code);
        bus.sel_valid = 1'b1;
        bus.sel       = code;
        tick();
        bus.sel_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests_run++;
        if ({bus.credit, bus.change, bus.drink, bus.dispense, bus.change_valid, bus.fault, bus.coin_reject, bus.busy} !== 35'd0) begin
            fails++;
            $display("FAIL reset_outputs got=%h exp=0", {bus.credit, bus.change, bus.drink, bus.dispense, bus.change_valid, bus.fault, bus.coin_reject, bus.busy});
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_exact_price();
        coin(2'b10); coin(2'b10); coin(2'b10);
        tests_run++;
        if (bus.credit !== 12'd300) begin fails++; $display("FAIL exact_credit got=%0d exp=300", bus.credit); end
        select(3'b001);
        tests_run++;
        if ({bus.busy, bus.dispense} !== 2'b10) begin fails++; $display("FAIL exact_check_cycle got=%b exp=10", {bus.busy, bus.dispense}); end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if ({bus.dispense, bus.drink} !== 4'b1001) begin fails++; $display("FAIL exact_dispense[%0d] got=%b exp=1001", i, {bus.dispense, bus.drink}); end
        end
        tick();
        tests_run++;
        if ({bus.dispense, bus.change_valid, bus.change} !== {1'b0, 1'b1, 12'd0}) begin
            fails++; $display("FAIL exact_change got=%b/%b/%0d exp=0/1/0", bus.dispense, bus.change_valid, bus.change);
        end
        tick();
        tests_run++;
        if ({bus.credit, bus.change_valid, bus.busy} !== {12'd0, 1'b0, 1'b0}) begin
            fails++; $display("FAIL exact_after got=%0d/%b/%b exp=0/0/0", bus.credit, bus.change_valid, bus.busy);
        end
    endtask

    task automatic test_change_due();
        coin(2'b11); coin(2'b10);
        select(3'b010);
        tests_run++;
        if (bus.credit !== 12'd600) begin fails++; $display("FAIL change_credit got=%0d exp=600", bus.credit); end
        for (int i = 0; i < 4; i++) begin
            tick();
            tests_run++;
            if ({bus.dispense, bus.drink} !== 4'b1010) begin fails++; $display("FAIL change_dispense[%0d] got=%b exp=1010", i, {bus.dispense, bus.drink}); end
        end
        tick();
        tests_run++;
        if ({bus.change_valid, bus.change} !== {1'b1, 12'd200}) begin fails++; $display("FAIL change_amount got=%b/%0d exp=1/200", bus.change_valid, bus.change); end
        tick();
    endtask

    task automatic test_insufficient_cancel();
        coin(2'b10); coin(2'b10); coin(2'b10);
        select(3'b100);
        tests_run++;
        if ({bus.busy, bus.fault} !== 2'b10) begin fails++; $display("FAIL insuf_check got=%b exp=10", {bus.busy, bus.fault}); end
        tick();
        tests_run++;
        if ({bus.fault, bus.busy, bus.dispense, bus.credit} !== {1'b1, 1'b0, 1'b0, 12'd300}) begin
            fails++; $display("FAIL insuf_fault got=%b/%b/%b/%0d exp=1/0/0/300", bus.fault, bus.busy, bus.dispense, bus.credit);
        end
        tick();
        tests_run++;
        if (bus.fault !== 1'b0) begin fails++; $display("FAIL insuf_fault_width got=%b exp=0", bus.fault); end
        bus.cancel = 1'b1; tick(); bus.cancel = 1'b0;
        tests_run++;
        if ({bus.change_valid, bus.change} !== {1'b1, 12'd300}) begin fails++; $display("FAIL cancel_refund got=%b/%0d exp=1/300", bus.change_valid, bus.change); end
        tick();
        tests_run++;
        if ({bus.credit, bus.change_valid} !== {12'd0, 1'b0}) begin fails++; $display("FAIL cancel_after got=%0d/%b exp=0/0", bus.credit, bus.change_valid); end
    endtask

    task automatic test_max_credit_reject();
        coin(2'b11); coin(2'b11);
        coin(2'b00);
        tests_run++;
        if ({bus.coin_reject, bus.credit} !== {1'b1, 12'd1000}) begin fails++; $display("FAIL max_reject got=%b/%0d exp=1/1000", bus.coin_reject, bus.credit); end
        tick();
        tests_run++;
        if (bus.coin_reject !== 1'b0) begin fails++; $display("FAIL max_reject_width got=%b exp=0", bus.coin_reject); end
        select(3'b011);
        tick();
        coin(2'b01);
        tests_run++;
        if ({bus.coin_reject, bus.dispense, bus.credit} !== {1'b1, 1'b1, 12'd1000}) begin
            fails++; $display("FAIL dispense_reject got=%b/%b/%0d exp=1/1/1000", bus.coin_reject, bus.dispense, bus.credit);
        end
        tick();
        tests_run++;
        if (bus.coin_reject !== 1'b0) begin fails++; $display("FAIL dispense_reject_width got=%b exp=0", bus.coin_reject); end
        tick();
        tick();
        tests_run++;
        if ({bus.change_valid, bus.change} !== {1'b1, 12'd500}) begin fails++; $display("FAIL max_change got=%b/%0d exp=1/500", bus.change_valid, bus.change); end
        tick();
    endtask

    task automatic test_timeout_invalid();
        coin(2'b01);
        for (int i = 0; i < 999; i++) tick();
        tests_run++;
        if ({bus.change_valid, bus.credit} !== {1'b0, 12'd50}) begin fails++; $display("FAIL timeout_early got=%b/%0d exp=0/50", bus.change_valid, bus.credit); end
        tick();
        tests_run++;
        if ({bus.change_valid, bus.change} !== {1'b1, 12'd50}) begin fails++; $display("FAIL timeout_refund got=%b/%0d exp=1/50", bus.change_valid, bus.change); end
        tick();
        select(3'b001);
        tests_run++;
        if ({bus.fault, bus.credit, bus.busy} !== {1'b1, 12'd0, 1'b0}) begin
            fails++; $display("FAIL idle_sel_fault got=%b/%0d/%b exp=1/0/0", bus.fault, bus.credit, bus.busy);
        end
        coin(2'b10);
        select(3'b111);
        tests_run++;
        if ({bus.fault, bus.credit, bus.busy} !== {1'b1, 12'd100, 1'b0}) begin
            fails++; $display("FAIL invalid_sel got=%b/%0d/%b exp=1/100/0", bus.fault, bus.credit, bus.busy);
        end
        bus.cancel = 1'b1; bus.coin_valid = 1'b1; bus.coin_val = 2'b00;
        tick();
        bus.cancel = 1'b0; bus.coin_valid = 1'b0;
        tests_run++;
        if ({bus.change_valid, bus.change} !== {1'b1, 12'd125}) begin fails++; $display("FAIL cancel_with_coin got=%b/%0d exp=1/125", bus.change_valid, bus.change); end
        tick();
    endtask

    task automatic test_same_cycle_and_reset();
        coin(2'b10); coin(2'b10);
        bus.coin_valid = 1'b1; bus.coin_val = 2'b10; bus.sel_valid = 1'b1; bus.sel = 3'b001;
        tick();
        bus.coin_valid = 1'b0; bus.sel_valid = 1'b0;
        tests_run++;
        if ({bus.credit, bus.busy} !== {12'd300, 1'b1}) begin fails++; $display("FAIL same_cycle_credit got=%0d/%b exp=300/1", bus.credit, bus.busy); end
        for (int i = 0; i < 5; i++) tick();
        tests_run++;
        if ({bus.change_valid, bus.change} !== {1'b1, 12'd0}) begin fails++; $display("FAIL same_cycle_change got=%b/%0d exp=1/0", bus.change_valid, bus.change); end
        tick();
        coin(2'b10); coin(2'b10);
        bus.coin_valid = 1'b1; bus.coin_val = 2'b10; bus.sel_valid = 1'b1; bus.sel = 3'b001;
        tick();
        bus.coin_valid = 1'b0; bus.sel_valid = 1'b0;
        tick();
        tick();
        tests_run++;
        if (bus.dispense !== 1'b1) begin fails++; $display("FAIL pre_reset_dispense got=%b exp=1", bus.dispense); end
        #2 rst = 1'b1;
        #1;
        tests_run++;
        if ({bus.credit, bus.change, bus.drink, bus.dispense, bus.change_valid, bus.fault, bus.coin_reject, bus.busy} !== 35'd0) begin
            fails++; $display("FAIL async_reset got=%h exp=0", {bus.credit, bus.change, bus.drink, bus.dispense, bus.change_valid, bus.fault, bus.coin_reject, bus.busy});
        end
        tick();
        rst = 1'b0;
        tick();
        tick();
        tests_run++;
        if ({bus.busy, bus.dispense, bus.credit, bus.change_valid} !== {1'b0, 1'b0, 12'd0, 1'b0}) begin
            fails++; $display("FAIL post_reset_idle got=%b/%b/%0d/%b exp=0/0/0/0", bus.busy, bus.dispense, bus.credit, bus.change_valid);
        end
        coin(2'b00);
        tests_run++;
        if (bus.credit !== 12'd25) begin fails++; $display("FAIL post_reset_coin got=%0d exp=25", bus.credit); end
        bus.cancel = 1'b1; tick(); bus.cancel = 1'b0;
        tick();
    endtask

    initial begin
        tests_run      = 0;
        fails          = 0;
        rst            = 1'b1;
        bus.coin_valid = 1'b0;
        bus.coin_val   = 2'b00;
        bus.sel_valid  = 1'b0;
        bus.sel        = 3'b000;
        bus.cancel     = 1'b0;
        test_reset();
        test_exact_price();
        test_change_due();
        test_insufficient_cancel();
        test_max_credit_reject();
        test_timeout_invalid();
        test_same_cycle_and_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule

// File: doc/vending_sequencer.md
# vending_sequencer

Vending sequencer: the control FSM for the vending machine's coin-credit and change datapath. It accumulates coin credit, evaluates a drink selection against its fixed price, and drives the dispense strobe. It then returns change, or refunds on cancel or inactivity timeout. It sits between the coin/keypad front end and the dispenser/coin-return actuators, and replaces ad-hoc edge-triggered selection logic with a single clocked controller.

## Interface
- `TIMEOUT_CYC`, default 1000: idle cycles in CREDIT before an automatic refund.
- `DISPENSE_CYC`, default 4: cycles that `dispense` stays high.
- `MAX_CREDIT`, default 1000: upper bound on accumulated credit.

Ports:
- `clk` in 1: rising-edge clock.
- `rst` in 1: reset, asynchronous, active-high.
- `coin_valid` in 1: one-cycle strobe, one coin inserted.
- `coin_val` in 2: coin code: 00=25, 01=50, 10=100, 11=500.
- `sel_valid` in 1: one-cycle strobe, selection made.
- `sel` in 3: drink code: 001=300, 010=400, 011=500, 100=700. Other codes are invalid.
- `cancel` in 1: one-cycle strobe, refund request.
- `credit` out 12: current accumulated credit.
- `dispense` out 1: dispenser drive.
- `drink` out 3: drink being dispensed. Valid while `dispense` is high, otherwise 0.
- `change` out 12: change/refund amount. Held until the next `change_valid`.
- `change_valid` out 1: one-cycle strobe, coin return must pay out `change`.
- `fault` out 1: one-cycle strobe, insufficient credit or invalid selection.
- `coin_reject` out 1: one-cycle strobe, coin not accepted and must be returned.
- `busy` out 1: high in CHECK, DISPENSE and CHANGE.

## Operation
- States: IDLE, CREDIT, CHECK, DISPENSE, CHANGE.
- Reset: state IDLE. All outputs are 0: `credit`, `change`, `drink`, `dispense`, `change_valid`, `fault`, `coin_reject`, `busy`. Internal timers and latched selection are cleared.

IDLE:
- Credit is 0.
- Accepted coin: add its value to credit and go to CREDIT.
- `sel_valid`: pulse `fault`, stay in IDLE.
- `cancel`: ignored.

CREDIT:
- Coin accepted if credit + value <= `MAX_CREDIT`. Otherwise pulse `coin_reject` and leave credit unchanged.
- Inactivity counter restarts on any `coin_valid`, `sel_valid` or `cancel`.
- Priority per cycle: `cancel` > `sel_valid`. A coin in the same cycle is still added, if accepted.
- `cancel`: go to CHANGE with refund = credit, including any coin added that cycle.
- Valid `sel`: latch the drink and go to CHECK. The comparison uses credit after any same-cycle coin is added.
- Invalid `sel`: pulse `fault`, stay in CREDIT.
- Counter reaches `TIMEOUT_CYC`: go to CHANGE with refund = credit.

CHECK (exactly 1 cycle):
- credit >= price: change register = credit - price, go to DISPENSE.
- credit < price: pulse `fault`, return to CREDIT with credit unchanged, and restart the inactivity counter.

DISPENSE:
- `dispense` is high and `drink` equals the latched code for exactly `DISPENSE_CYC` cycles, then go to CHANGE.

CHANGE (1 cycle):
- `change_valid` is high and `change` is driven with the computed amount. A zero amount is still strobed.
- Credit is cleared and the state goes to IDLE.

Other rules:
- In CHECK, DISPENSE and CHANGE, coins are rejected (`coin_reject` pulse) and `sel_valid`/`cancel` are ignored.
- Arithmetic is 12-bit unsigned. `MAX_CREDIT` <= 4095 guarantees no overflow. The subtraction is performed only when credit >= price, so there is no underflow.

## Timing
- All outputs are registered. There are no combinational input-to-output paths.
- Accepted coin at edge n: `credit` reflects it from cycle n+1.
- Rejected coin at edge n: `coin_reject` is high in cycle n+1 only.
- Selection at edge n:
  - CHECK in cycle n+1.
  - Sufficient credit: `dispense` high in cycles n+2 .. n+1+`DISPENSE_CYC`, then `change_valid` in cycle n+2+`DISPENSE_CYC`, with `credit` = 0 from the following cycle.
  - Insufficient credit: `fault` high in cycle n+2, with the state back in CREDIT.
- Cancel at edge n: `change_valid` in cycle n+1. `credit` = 0 from cycle n+2.
- Timeout: refund `change_valid` exactly `TIMEOUT_CYC`+1 cycles after the last activity strobe.
- `rst` mid-operation (including DISPENSE) forces all outputs to 0 asynchronously. A partial credit is lost and not refunded.

## Test plan
- Insert coins 100, 100, 100, then sel=001 → `dispense` high 4 cycles with `drink`=001, then `change_valid` with `change`=0 and `credit`=0.
- Insert 500 then 100, then sel=010 → `dispense` high 4 cycles, then `change_valid` with `change`=200.
- Credit 300, sel=100 → `fault` one cycle, `credit` stays 300. Then `cancel` → `change_valid` with `change`=300.
- Insert 500, 500, then 25 → `coin_reject` one cycle, `credit`=1000. Coin strobed during DISPENSE → `coin_reject`.
- Insert 50, then no activity for 1000 cycles → `change_valid` with `change`=50, state IDLE. Invalid sel=111 in CREDIT → `fault`, credit unchanged.
- Coin 100 and sel=001 in the same cycle with credit 200 → dispense, `change`=0. Assert `rst` in DISPENSE cycle 2 → all outputs 0 immediately, IDLE after release.
